// File: rtl/dir_pkg.sv
// Shared encodings for the direction-key front end: direction codes, FSM states
// and the one-hot key to direction-code helpers.
package dir_pkg;

    localparam int unsigned BTN_W = 4;
    localparam int unsigned DIR_W = 2;

    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b00;
    localparam logic [DIR_W-1:0] DIR_UP    = 2'b01;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b10;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_HELD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_RELEASE  = 3'd4
    } state_e;

    function automatic logic [DIR_W-1:0] onehot_to_dir(input logic [BTN_W-1:0] oh);
        logic [DIR_W-1:0] code;
        case (oh)
            4'b0001: code = DIR_LEFT;
            4'b0010: code = DIR_UP;
            4'b0100: code = DIR_DOWN;
            4'b1000: code = DIR_RIGHT;
            default: code = DIR_LEFT;
        endcase
        return code;
    endfunction

    function automatic logic is_single(input logic [BTN_W-1:0] v);
        return (v != '0) && ((v & (v - BTN_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/dir_key_encoder_if.sv
// Button input and direction/strobe output bundle between the key front end
// and its environment.
interface dir_key_encoder_if;
    import dir_pkg::*;

    logic [BTN_W-1:0] BTN_N;
    logic [DIR_W-1:0] Dir_out;
    logic             Enable;
    logic             Held;

    modport master (output BTN_N, input Dir_out, input Enable, input Held);
    modport slave  (input BTN_N, output Dir_out, output Enable, output Held);
endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw active-low buttons; resets to "released".
module btn_sync
    import dir_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BTN_W-1:0] btn_n_i,
    output logic [BTN_W-1:0] btn_n_o
);

    logic [BTN_W-1:0] meta_q;
    logic [BTN_W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= btn_n_i;
            sync_q <= meta_q;
        end
    end

    assign btn_n_o = sync_q;

endmodule

// File: rtl/dir_key_encoder.sv
// Debounces four direction keys, rejects chords and emits one Enable strobe per
// accepted press, optionally auto-repeating while the key stays held.
module dir_key_encoder
    import dir_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned CNT_W           = 25
) (
    input logic              CLOCK,
    input logic              RESET,
    dir_key_encoder_if.slave bus
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [BTN_W-1:0] btn_sync_n;
    logic [BTN_W-1:0] pressed;
    logic             single;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [BTN_W-1:0] cand_q, cand_d;
    logic             enable_q, enable_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic             held_q, held_d;

    btn_sync u_btn_sync (
        .clk     (CLOCK),
        .rst     (RESET),
        .btn_n_i (bus.BTN_N),
        .btn_n_o (btn_sync_n)
    );

    assign pressed = ~btn_sync_n;
    assign single  = is_single(pressed);
    // Saturating increment so an indefinitely held key never wraps the counter.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cand_q   <= '0;
            enable_q <= 1'b0;
            dir_q    <= DIR_LEFT;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            enable_q <= enable_d;
            dir_q    <= dir_d;
            held_q   <= held_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        enable_d = 1'b0;
        dir_d    = dir_q;

        case (state_q)
            ST_IDLE: begin
                if (single) begin
                    cand_d  = pressed;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (pressed != cand_q) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d    = '0;
                    enable_d = 1'b1;
                    dir_d    = onehot_to_dir(cand_q);
                    state_d  = ST_HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HELD: begin
                if (pressed != cand_q) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (REPEAT_EN && (cnt_q == DLY_LAST)) begin
                    cnt_d    = '0;
                    enable_d = 1'b1;
                    state_d  = ST_REPEAT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REPEAT: begin
                if (pressed != cand_q) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (cnt_q == PER_LAST) begin
                    cnt_d    = '0;
                    enable_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                // Every key must stay released for a full debounce window.
                if (pressed != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        held_d = (state_d == ST_HELD) || (state_d == ST_REPEAT);
    end

    assign bus.Enable  = enable_q;
    assign bus.Dir_out = dir_q;
    assign bus.Held    = held_q;

endmodule

// File: tb/tb_dir_key_encoder.sv
// Scoreboard bench for dir_key_encoder: one instance without and one with
// auto-repeat, both driven by the same button stimulus.
module tb_dir_key_encoder;
    import dir_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned DLY = 10;
    localparam int unsigned PER = 5;
    localparam int unsigned CW  = 8;
    // Drive at a falling edge -> Enable seen after rising edge (drive + LAT).
    localparam int LAT = int'(DEB) + 3;
    // Release driven at a falling edge -> FSM leaves HELD/REPEAT at (drive + 3).
    localparam int REL = 3;

    typedef struct {
        int         cyc;
        logic [1:0] dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    dir_key_encoder_if bus0 ();
    dir_key_encoder_if bus1 ();

    dir_key_encoder #(
        .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b0), .REPEAT_DELAY(DLY),
        .REPEAT_PERIOD(PER), .CNT_W(CW)
    ) dut0 (.CLOCK(clk), .RESET(rst), .bus(bus0));

    dir_key_encoder #(
        .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b1), .REPEAT_DELAY(DLY),
        .REPEAT_PERIOD(PER), .CNT_W(CW)
    ) dut1 (.CLOCK(clk), .RESET(rst), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_btn(input logic [3:0] v);
        bus0.BTN_N = v;
        bus1.BTN_N = v;
    endtask

    // Expected strobes for a press accepted at first_en; the key leaves
    // HELD/REPEAT at edge rel_edge.
    task automatic push_exp(input int first_en, input int rel_edge, input logic [1:0] d);
        int k;
        if (first_en < rel_edge) begin
            q0.push_back('{cyc: first_en, dir: d});
            q1.push_back('{cyc: first_en, dir: d});
            k = first_en + int'(DLY);
            while (k < rel_edge) begin
                q1.push_back('{cyc: k, dir: d});
                k += int'(PER);
            end
        end
    endtask

    // Advance to the next falling edge and score any strobe from either DUT.
    task automatic tick(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus0.Enable === 1'b1) begin
                checks++;
                if (prev0) begin
                    errors++;
                    $display("FAIL en0_consecutive cyc=%0d got=1 exp=0", cyc);
                end
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL en0_unexpected cyc=%0d dir=%b exp=none", cyc, bus0.Dir_out);
                end else begin
                    e = q0.pop_front();
                    if (cyc !== e.cyc || bus0.Dir_out !== e.dir) begin
                        errors++;
                        $display("FAIL en0_event got cyc=%0d dir=%b exp cyc=%0d dir=%b",
                                 cyc, bus0.Dir_out, e.cyc, e.dir);
                    end
                end
            end
            if (bus1.Enable === 1'b1) begin
                checks++;
                if (prev1) begin
                    errors++;
                    $display("FAIL en1_consecutive cyc=%0d got=1 exp=0", cyc);
                end
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL en1_unexpected cyc=%0d dir=%b exp=none", cyc, bus1.Dir_out);
                end else begin
                    e = q1.pop_front();
                    if (cyc !== e.cyc || bus1.Dir_out !== e.dir) begin
                        errors++;
                        $display("FAIL en1_event got cyc=%0d dir=%b exp cyc=%0d dir=%b",
                                 cyc, bus1.Dir_out, e.cyc, e.dir);
                    end
                end
            end
            prev0 = bus0.Enable;
            prev1 = bus1.Enable;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_btn(4'b0000);
        for (int i = 0; i < 13; i++) begin
            if (i == 3) rst = 1'b0;
            tick(1);
            checks++;
            if ({bus0.Enable, bus0.Held, bus0.Dir_out} !== 4'b0000 ||
                {bus1.Enable, bus1.Held, bus1.Dir_out} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs i=%0d got0=%b got1=%b exp=0000", i,
                         {bus0.Enable, bus0.Held, bus0.Dir_out},
                         {bus1.Enable, bus1.Held, bus1.Dir_out});
            end
        end
        set_btn(4'b1111);
        tick(6);
    endtask

    task automatic test_single_press();
        int c;
        c = cyc;
        set_btn(4'b0111);
        push_exp(c + LAT, c + 30 + REL, DIR_RIGHT);
        tick(30);
        set_btn(4'b1111);
        tick(2);
        checks++;
        if (bus0.Held !== 1'b1 || bus1.Held !== 1'b1) begin
            errors++;
            $display("FAIL held_before_release got=%b%b exp=11", bus0.Held, bus1.Held);
        end
        tick(1);
        checks++;
        if (bus0.Held !== 1'b0 || bus1.Held !== 1'b0) begin
            errors++;
            $display("FAIL held_after_release got=%b%b exp=00", bus0.Held, bus1.Held);
        end
        tick(8);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL single_missing got=%0d/%0d pending exp=0", q0.size(), q1.size());
        end
        checks++;
        if (bus0.Dir_out !== DIR_RIGHT) begin
            errors++;
            $display("FAIL dir_hold got=%b exp=%b", bus0.Dir_out, DIR_RIGHT);
        end
    endtask

    task automatic test_bounce();
        int c;
        for (int i = 0; i < 4; i++) begin
            set_btn(4'b1101);
            tick(2);
            set_btn(4'b1111);
            tick(2);
        end
        c = cyc;
        set_btn(4'b1101);
        push_exp(c + LAT, c + 20 + REL, DIR_UP);
        tick(20);
        set_btn(4'b1111);
        tick(10);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL bounce_missing got=%0d/%0d pending exp=0", q0.size(), q1.size());
        end
        checks++;
        if (bus1.Dir_out !== DIR_UP) begin
            errors++;
            $display("FAIL bounce_dir got=%b exp=%b", bus1.Dir_out, DIR_UP);
        end
    endtask

    task automatic test_chord();
        int c;
        set_btn(4'b0110);
        tick(20);
        checks++;
        if (bus0.Held !== 1'b0 || bus1.Held !== 1'b0) begin
            errors++;
            $display("FAIL chord_held got=%b%b exp=00", bus0.Held, bus1.Held);
        end
        set_btn(4'b1111);
        tick(10);
        c = cyc;
        set_btn(4'b1011);
        push_exp(c + LAT, c + 15 + REL, DIR_DOWN);
        tick(15);
        set_btn(4'b1111);
        tick(10);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL chord_missing got=%0d/%0d pending exp=0", q0.size(), q1.size());
        end
    endtask

    task automatic test_repeat();
        int c;
        c = cyc;
        set_btn(4'b1110);
        push_exp(c + LAT, c + 40 + REL, DIR_LEFT);
        tick(40);
        set_btn(4'b1111);
        tick(12);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL repeat_missing got=%0d/%0d pending exp=0", q0.size(), q1.size());
        end
        checks++;
        if (bus1.Held !== 1'b0) begin
            errors++;
            $display("FAIL repeat_held_after got=%b exp=0", bus1.Held);
        end
    endtask

    task automatic test_reset_repeat();
        int c;
        c = cyc;
        set_btn(4'b1110);
        push_exp(c + LAT, c + 21, DIR_LEFT);
        tick(20);
        checks++;
        if (bus1.Held !== 1'b1) begin
            errors++;
            $display("FAIL rr_held_pre got=%b exp=1", bus1.Held);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if ({bus0.Enable, bus0.Held, bus0.Dir_out} !== 4'b0000 ||
            {bus1.Enable, bus1.Held, bus1.Dir_out} !== 4'b0000) begin
            errors++;
            $display("FAIL rr_cleared got0=%b got1=%b exp=0000",
                     {bus0.Enable, bus0.Held, bus0.Dir_out},
                     {bus1.Enable, bus1.Held, bus1.Dir_out});
        end
        push_exp(c + 21 + LAT, c + 40 + REL, DIR_LEFT);
        tick(19);
        set_btn(4'b1111);
        tick(12);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL rr_missing got=%0d/%0d pending exp=0", q0.size(), q1.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        set_btn(4'b0000);
        test_reset();
        test_single_press();
        test_bounce();
        test_chord();
        test_repeat();
        test_reset_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
